// File: rtl/axi4lite_cmd_master.sv
// Single-outstanding AXI4-Lite master: one command in, one AXI transaction out,
// one response back. Every AXI output comes straight from a flop.
module axi4lite_cmd_master #(
    parameter int C_M_AXI_ADDR_WIDTH = 6,
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int TIMEOUT_CYCLES     = 256
) (
    input  logic                          M_AXI_ACLK,
    input  logic                          M_AXI_ARESET,
    input  logic                          cmdValid,
    output logic                          cmdReady,
    input  logic                          cmdWrite,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0] cmdAddr,
    input  logic [C_M_AXI_DATA_WIDTH-1:0] cmdWdata,
    output logic                          rspValid,
    input  logic                          rspReady,
    output logic [C_M_AXI_DATA_WIDTH-1:0] rspData,
    output logic [1:0]                    rspResp,
    output logic                          rspTimeout,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_AWADDR,
    output logic                          M_AXI_AWVALID,
    input  logic                          M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_WDATA,
    output logic [3:0]                    M_AXI_WSTRB,
    output logic                          M_AXI_WVALID,
    input  logic                          M_AXI_WREADY,
    input  logic [1:0]                    M_AXI_BRESP,
    input  logic                          M_AXI_BVALID,
    output logic                          M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR,
    output logic                          M_AXI_ARVALID,
    input  logic                          M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_RDATA,
    input  logic [1:0]                    M_AXI_RRESP,
    input  logic                          M_AXI_RVALID,
    output logic                          M_AXI_RREADY
);
    localparam int AW = C_M_AXI_ADDR_WIDTH;
    localparam int DW = C_M_AXI_DATA_WIDTH;
    localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TW-1:0] TMO_LAST = (TIMEOUT_CYCLES > 0) ? TW'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP} state_t;

    state_t          state, state_n;
    logic            cmd_ready_q, cmd_ready_n;
    logic [AW-1:0]   addr_q, addr_n;
    logic [DW-1:0]   wdata_q, wdata_n;
    logic            awvalid_q, awvalid_n, wvalid_q, wvalid_n, bready_q, bready_n;
    logic            arvalid_q, arvalid_n, rready_q, rready_n;
    logic [DW-1:0]   rsp_data_q, rsp_data_n;
    logic [1:0]      rsp_resp_q, rsp_resp_n;
    logic            rsp_tmo_q, rsp_tmo_n;
    logic [TW-1:0]   tmo_cnt, tmo_n;
    logic            busy, expire, do_tmo, aw_left, w_left;

    always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
        if (M_AXI_ARESET) begin
            state       <= IDLE;
            cmd_ready_q <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            rsp_data_q  <= '0;
            rsp_resp_q  <= 2'b00;
            rsp_tmo_q   <= 1'b0;
            tmo_cnt     <= '0;
        end else begin
            state       <= state_n;
            cmd_ready_q <= cmd_ready_n;
            addr_q      <= addr_n;
            wdata_q     <= wdata_n;
            awvalid_q   <= awvalid_n;
            wvalid_q    <= wvalid_n;
            bready_q    <= bready_n;
            arvalid_q   <= arvalid_n;
            rready_q    <= rready_n;
            rsp_data_q  <= rsp_data_n;
            rsp_resp_q  <= rsp_resp_n;
            rsp_tmo_q   <= rsp_tmo_n;
            tmo_cnt     <= tmo_n;
        end
    end

    always_comb begin
        state_n    = state;
        addr_n     = addr_q;
        wdata_n    = wdata_q;
        awvalid_n  = awvalid_q;
        wvalid_n   = wvalid_q;
        bready_n   = bready_q;
        arvalid_n  = arvalid_q;
        rready_n   = rready_q;
        rsp_data_n = rsp_data_q;
        rsp_resp_n = rsp_resp_q;
        rsp_tmo_n  = rsp_tmo_q;
        tmo_n      = tmo_cnt;
        do_tmo     = 1'b0;
        aw_left    = awvalid_q && !M_AXI_AWREADY;
        w_left     = wvalid_q && !M_AXI_WREADY;
        busy       = (state == WR_REQ) || (state == WR_RESP) ||
                     (state == RD_REQ) || (state == RD_DATA);
        // Budget covers the whole transaction; saturate so it can never wrap.
        expire     = (TIMEOUT_CYCLES != 0) && (tmo_cnt >= TMO_LAST);
        if (busy && (TIMEOUT_CYCLES != 0) && (tmo_cnt < TMO_MAX))
            tmo_n = tmo_cnt + 1'b1;

        case (state)
            IDLE: begin
                if (cmdValid && cmd_ready_q) begin
                    addr_n    = cmdAddr & ~AW'(3);
                    wdata_n   = cmdWdata;
                    tmo_n     = '0;
                    rsp_tmo_n = 1'b0;
                    if (cmdWrite) begin
                        state_n   = WR_REQ;
                        awvalid_n = 1'b1;
                        wvalid_n  = 1'b1;
                    end else begin
                        state_n   = RD_REQ;
                        arvalid_n = 1'b1;
                    end
                end
            end
            WR_REQ: begin
                if (awvalid_q && M_AXI_AWREADY) awvalid_n = 1'b0;
                if (wvalid_q && M_AXI_WREADY)   wvalid_n  = 1'b0;
                if (!aw_left && !w_left) begin
                    state_n  = WR_RESP;
                    bready_n = 1'b1;
                end else if (expire) begin
                    do_tmo = 1'b1;
                end
            end
            WR_RESP: begin
                if (M_AXI_BVALID) begin
                    bready_n   = 1'b0;
                    rsp_data_n = '0;
                    rsp_resp_n = M_AXI_BRESP;
                    state_n    = RSP;
                end else if (expire) begin
                    do_tmo = 1'b1;
                end
            end
            RD_REQ: begin
                if (M_AXI_ARREADY) begin
                    arvalid_n = 1'b0;
                    rready_n  = 1'b1;
                    state_n   = RD_DATA;
                end else if (expire) begin
                    do_tmo = 1'b1;
                end
            end
            RD_DATA: begin
                if (M_AXI_RVALID) begin
                    rready_n   = 1'b0;
                    rsp_data_n = M_AXI_RDATA;
                    rsp_resp_n = M_AXI_RRESP;
                    state_n    = RSP;
                end else if (expire) begin
                    do_tmo = 1'b1;
                end
            end
            RSP: begin
                if (rspReady) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase

        // Hang recovery: withdraw everything and report a synthetic SLVERR.
        if (do_tmo) begin
            awvalid_n  = 1'b0;
            wvalid_n   = 1'b0;
            bready_n   = 1'b0;
            arvalid_n  = 1'b0;
            rready_n   = 1'b0;
            rsp_data_n = '0;
            rsp_resp_n = 2'b10;
            rsp_tmo_n  = 1'b1;
            state_n    = RSP;
        end
        cmd_ready_n = (state_n == IDLE);
    end

    assign cmdReady      = cmd_ready_q;
    assign rspValid      = (state == RSP);
    assign rspData       = rsp_data_q;
    assign rspResp       = rsp_resp_q;
    assign rspTimeout    = rsp_tmo_q;
    assign M_AXI_AWADDR  = addr_q;
    assign M_AXI_AWVALID = awvalid_q;
    assign M_AXI_WDATA   = wdata_q;
    assign M_AXI_WSTRB   = 4'hF;
    assign M_AXI_WVALID  = wvalid_q;
    assign M_AXI_BREADY  = bready_q;
    assign M_AXI_ARADDR  = addr_q;
    assign M_AXI_ARVALID = arvalid_q;
    assign M_AXI_RREADY  = rready_q;
endmodule

// File: tb/tb_axi4lite_cmd_master.sv
// Bench for axi4lite_cmd_master: behavioural slave with tunable ready delays,
// expected responses queued at command time and popped on each response handshake.
module tb_axi4lite_cmd_master;
    localparam int AW  = 6;
    localparam int DW  = 32;
    localparam int TMO = 16;

    typedef struct {
        logic [31:0] d;
        logic [1:0]  r;
        logic        t;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          cmdValid, cmdReady, cmdWrite, rspValid, rspReady, rspTimeout;
    logic [AW-1:0] cmdAddr;
    logic [DW-1:0] cmdWdata, rspData;
    logic [1:0]    rspResp;
    logic [AW-1:0] awaddr, araddr;
    logic          awvalid, awready, wvalid, wready, bvalid, bready;
    logic          arvalid, arready, rvalid, rready;
    logic [DW-1:0] wdata, rdata;
    logic [3:0]    wstrb;
    logic [1:0]    bresp, rresp;

    axi4lite_cmd_master #(
        .C_M_AXI_ADDR_WIDTH(AW), .C_M_AXI_DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .M_AXI_ACLK(clk), .M_AXI_ARESET(rst),
        .cmdValid(cmdValid), .cmdReady(cmdReady), .cmdWrite(cmdWrite),
        .cmdAddr(cmdAddr), .cmdWdata(cmdWdata),
        .rspValid(rspValid), .rspReady(rspReady), .rspData(rspData),
        .rspResp(rspResp), .rspTimeout(rspTimeout),
        .M_AXI_AWADDR(awaddr), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
        .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
        .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
        .M_AXI_ARADDR(araddr), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
        .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
    );

    // Slave: readies after a programmable number of waiting cycles; 0x3C answers SLVERR.
    int          aw_dly = 0, w_dly = 0, ar_dly = 0;
    logic        ar_block = 1'b0;
    int          aw_wait, w_wait, ar_wait, b_count = 0;
    logic [31:0] mem [0:15];
    logic        mem_ok = 1'b0;
    logic        got_aw, got_w;
    logic [5:0]  waddr_l;
    logic [31:0] wdata_l;
    logic [5:0]  s_wa;
    logic [31:0] s_wd;

    assign awready = awvalid && (aw_wait >= aw_dly);
    assign wready  = wvalid && (w_wait >= w_dly);
    assign arready = arvalid && !ar_block && (ar_wait >= ar_dly);
    assign s_wa    = (awvalid && awready) ? awaddr : waddr_l;
    assign s_wd    = (wvalid && wready) ? wdata : wdata_l;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            bvalid <= 1'b0; rvalid <= 1'b0; got_aw <= 1'b0; got_w <= 1'b0;
            aw_wait <= 0; w_wait <= 0; ar_wait <= 0;
            rdata <= '0; rresp <= 2'b00; bresp <= 2'b00; waddr_l <= '0; wdata_l <= '0;
            if (!mem_ok) begin
                for (int i = 0; i < 16; i++) mem[i] <= 32'h5100_0000 + 32'(i);
                mem[1] <= 32'h1234_5678;
                mem_ok <= 1'b1;
            end
        end else begin
            aw_wait <= (awvalid && !awready) ? aw_wait + 1 : 0;
            w_wait  <= (wvalid && !wready) ? w_wait + 1 : 0;
            ar_wait <= (arvalid && !arready) ? ar_wait + 1 : 0;
            if (awvalid && awready) begin got_aw <= 1'b1; waddr_l <= awaddr; end
            if (wvalid && wready)   begin got_w <= 1'b1; wdata_l <= wdata; end
            if ((got_aw || (awvalid && awready)) && (got_w || (wvalid && wready)) && !bvalid) begin
                mem[s_wa[5:2]] <= s_wd;
                bresp  <= (s_wa >= 6'h3C) ? 2'b10 : 2'b00;
                bvalid <= 1'b1;
                got_aw <= 1'b0;
                got_w  <= 1'b0;
            end
            if (bvalid && bready) begin bvalid <= 1'b0; b_count <= b_count + 1; end
            if (rvalid && rready) rvalid <= 1'b0;
            if (arvalid && arready) begin
                rvalid <= 1'b1;
                rdata  <= mem[araddr[5:2]];
                rresp  <= (araddr >= 6'h3C) ? 2'b10 : 2'b00;
            end
        end
    end

    int          n_chk = 0, n_fail = 0;
    exp_t        sb[$];
    logic [31:0] shadow [0:15];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && rspValid && rspReady) begin
            if (sb.size() == 0) begin
                chk("rsp_unexpected", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("rsp_data", rspData, e.d);
                chk("rsp_resp", 32'(rspResp), 32'(e.r));
                chk("rsp_timeout", 32'(rspTimeout), 32'(e.t));
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Returns one cycle after acceptance (cycle 1 of the transaction).
    task automatic send(input logic wr, input logic [5:0] a, input logic [31:0] d, input logic tmo);
        int   n;
        exp_t e;
        n = 0;
        while (!cmdReady && n < 50) begin tick; n++; end
        chk("cmd_ready_wait", 32'(n < 50), 32'd1);
        cmdValid = 1'b1; cmdWrite = wr; cmdAddr = a; cmdWdata = d;
        e.t = 1'b0;
        e.r = (a >= 6'h3C) ? 2'b10 : 2'b00;
        if (tmo) begin
            e.d = '0; e.r = 2'b10; e.t = 1'b1;
        end else if (wr) begin
            shadow[a[5:2]] = d;
            e.d = '0;
        end else begin
            e.d = shadow[a[5:2]];
        end
        sb.push_back(e);
        tick;
        cmdValid = 1'b0; cmdWrite = 1'($urandom);
        cmdAddr = 6'($urandom); cmdWdata = $urandom;
    endtask

    task automatic wait_rsp(input int hold, output int lat);
        logic        bad;
        logic [31:0] d0;
        lat = 1;
        while (!rspValid && lat < 200) begin tick; lat++; end
        chk("rsp_valid_wait", 32'(rspValid), 32'd1);
        bad = 1'b0;
        d0  = rspData;
        for (int i = 0; i < hold; i++) begin
            tick;
            if (!rspValid || rspData !== d0 || cmdReady) bad = 1'b1;
        end
        if (hold > 0) chk("rsp_hold_stable", 32'(bad), 32'd0);
        rspReady = 1'b1;
        tick;
        rspReady = 1'b0;
        chk("idle_after_rsp", 32'(cmdReady), 32'd1);
        chk("rsp_drop", 32'(rspValid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, cnt, bc0;
        logic wr;
        logic [5:0] a;
        cmdValid = 1'b0; cmdWrite = 1'b0; cmdAddr = '0; cmdWdata = '0; rspReady = 1'b0;
        for (int i = 0; i < 16; i++) shadow[i] = 32'h5100_0000 + 32'(i);
        shadow[1] = 32'h1234_5678;

        tick; tick; tick;
        chk("rst_cmd_ready", 32'(cmdReady), 32'd0);
        chk("rst_valids", {27'd0, awvalid, wvalid, bready, arvalid, rready}, 32'd0);
        chk("rst_rsp_valid", 32'(rspValid), 32'd0);
        chk("rst_rsp_fields", rspData | 32'(rspResp) | 32'(rspTimeout), 32'd0);
        rst = 1'b0;

        // zero-wait write: AW/W together in cycle 1, response in cycle 3
        send(1'b1, 6'h00, 32'hDEAD_BEEF, 1'b0);
        chk("wr_aw_c1", 32'(awvalid), 32'd1);
        chk("wr_w_c1", 32'(wvalid), 32'd1);
        chk("wr_wstrb", 32'(wstrb), 32'hF);
        chk("wr_awaddr", 32'(awaddr), 32'h00);
        chk("wr_wdata", wdata, 32'hDEAD_BEEF);
        wait_rsp(0, lat);
        chk("wr_latency", lat, 3);

        send(1'b0, 6'h04, 32'h0, 1'b0);
        chk("rd_araddr", 32'(araddr), 32'h04);
        chk("rd_arvalid_c1", 32'(arvalid), 32'd1);
        wait_rsp(0, lat);
        chk("rd_latency", lat, 3);
        send(1'b0, 6'h00, 32'h0, 1'b0);
        wait_rsp(0, lat);

        // unaligned addresses are forced to word alignment
        send(1'b1, 6'h0B, 32'h0B0B_0B0B, 1'b0);
        chk("unal_awaddr", 32'(awaddr), 32'h08);
        wait_rsp(0, lat);
        send(1'b0, 6'h09, 32'h0, 1'b0);
        chk("unal_araddr", 32'(araddr), 32'h08);
        wait_rsp(0, lat);

        // slave error passes through on both channels
        send(1'b1, 6'h3C, 32'h3C3C_0000, 1'b0);
        wait_rsp(0, lat);
        send(1'b0, 6'h3E, 32'h0, 1'b0);
        wait_rsp(0, lat);

        // WREADY five cycles late: AW drops alone, W held, one B
        w_dly = 5;
        bc0 = b_count;
        send(1'b1, 6'h14, 32'hCAFE_0014, 1'b0);
        tick;
        chk("dly_aw_drop", 32'(awvalid), 32'd0);
        cnt = 0;
        for (int c = 2; c <= 6; c++) begin
            if (wvalid) cnt++;
            tick;
        end
        chk("dly_w_hold", cnt, 5);
        chk("dly_w_drop", 32'(wvalid), 32'd0);
        wait_rsp(0, lat);
        chk("dly_single_b", b_count - bc0, 1);
        w_dly = 0;

        // AW late instead of W
        aw_dly = 3;
        send(1'b1, 6'h18, 32'h0000_A018, 1'b0);
        wait_rsp(0, lat);
        aw_dly = 0;
        send(1'b0, 6'h18, 32'h0, 1'b0);
        wait_rsp(0, lat);

        // response back-pressure
        send(1'b0, 6'h14, 32'h0, 1'b0);
        wait_rsp(10, lat);

        // ARREADY on the last budgeted cycle: handshake beats the timeout
        ar_dly = TMO - 1;
        send(1'b0, 6'h04, 32'h0, 1'b0);
        wait_rsp(0, lat);
        chk("tmo_edge_latency", lat, TMO + 2);
        ar_dly = 0;

        // ARREADY never comes
        ar_block = 1'b1;
        send(1'b0, 6'h10, 32'h0, 1'b1);
        cnt = 0;
        for (int c = 1; c <= TMO; c++) begin
            if (arvalid) cnt++;
            tick;
        end
        chk("tmo_ar_cycles", cnt, TMO);
        chk("tmo_ar_drop", 32'(arvalid), 32'd0);
        chk("tmo_flag", 32'(rspTimeout), 32'd1);
        wait_rsp(0, lat);
        ar_block = 1'b0;
        send(1'b1, 6'h10, 32'h1010_1010, 1'b0);
        chk("tmo_flag_clear", 32'(rspTimeout), 32'd0);
        wait_rsp(0, lat);

        // reset while waiting for B
        send(1'b1, 6'h20, 32'hA5A5_0001, 1'b0);
        tick;
        chk("rst_mid_bready", 32'(bready), 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_mid_valids", {27'd0, awvalid, wvalid, bready, arvalid, rready}, 32'd0);
        chk("rst_mid_rsp", {30'd0, rspValid, cmdReady}, 32'd0);
        sb.delete();
        tick; tick;
        rst = 1'b0;
        tick;
        chk("rst_mid_no_rsp", 32'(rspValid), 32'd0);
        send(1'b0, 6'h20, 32'h0, 1'b0);
        wait_rsp(0, lat);
        chk("rst_mid_latency", lat, 3);

        // random mix with small slave delays
        for (int k = 0; k < 24; k++) begin
            aw_dly = $urandom_range(0, 3);
            w_dly  = $urandom_range(0, 3);
            ar_dly = $urandom_range(0, 3);
            wr = 1'($urandom);
            a  = 6'($urandom);
            send(wr, a, $urandom, 1'b0);
            wait_rsp($urandom_range(0, 2), lat);
        end

        tick; tick;
        chk("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
